// File: rtl/key_debounce_array.sv
// N-channel push-button debouncer: 2-flop synchroniser, 4-state debounce FSM with
// glitch abort, registered press/release/long-press strobes and a long-held level.
module key_debounce_array #(
  parameter int   N_KEYS       = 4,
  parameter int   CNT_W        = 26,
  parameter int   DEBOUNCE_CYC = 500_000,
  parameter int   LONG_CYC     = 50_000_000,
  parameter logic ACTIVE_LEVEL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] long_held
);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [N_KEYS-1:0] sync_p0;
  logic [N_KEYS-1:0] sync_p1;

  // Stage p0/p1: metastability synchroniser, parked at the released level in reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= {N_KEYS{~ACTIVE_LEVEL}};
      sync_p1 <= {N_KEYS{~ACTIVE_LEVEL}};
    end else begin
      sync_p0 <= key;
      sync_p1 <= sync_p0;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             p;
    logic             key_state_q, press_q, release_q, long_q, long_held_q;
    logic             key_state_nxt, press_nxt, release_nxt, long_nxt, long_held_nxt;

    assign p = (sync_p1[i] == ACTIVE_LEVEL);

    // Stage p2: FSM state, counter and all outputs are registered together
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state       <= IDLE;
        cnt         <= '0;
        key_state_q <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
        long_held_q <= 1'b0;
      end else begin
        state       <= state_nxt;
        cnt         <= cnt_nxt;
        key_state_q <= key_state_nxt;
        press_q     <= press_nxt;
        release_q   <= release_nxt;
        long_q      <= long_nxt;
        long_held_q <= long_held_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
        IDLE: begin
          if (p) begin
            state_nxt = PRESS_CHK;
            cnt_nxt   = '0;
          end
        end
        PRESS_CHK: begin
          if (!p) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == DEB_LAST) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!p) begin
            state_nxt = REL_CHK;
            cnt_nxt   = '0;
          end else if (cnt != LONG_LAST) begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        REL_CHK: begin
          // A return to HELD restarts long-press timing from zero
          if (p) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else if (cnt == DEB_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    always_comb begin
      press_nxt     = (state == PRESS_CHK) && p && (cnt == DEB_LAST);
      release_nxt   = (state == REL_CHK) && !p && (cnt == DEB_LAST);
      long_nxt      = (state == HELD) && p && (cnt == LONG_LAST) && !long_held_q;
      key_state_nxt = (state_nxt == HELD) || (state_nxt == REL_CHK);
      long_held_nxt = key_state_nxt && (long_held_q || long_nxt);
    end

    assign key_state[i]     = key_state_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
    assign long_pulse[i]    = long_q;
    assign long_held[i]     = long_held_q;
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: run-length behavioural model checked every cycle,
// plus directed scenarios with hand-computed pulse timing.
module tb_key_debounce_array;
  localparam int N = 4;
  localparam int D = 8;
  localparam int L = 32;
  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] key   = '0;
  logic [N-1:0] key_state, press_pulse, release_pulse, long_pulse, long_held;

  key_debounce_array #(
    .N_KEYS(N), .CNT_W(W), .DEBOUNCE_CYC(D), .LONG_CYC(L), .ACTIVE_LEVEL(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .key(key),
    .key_state(key_state), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .long_held(long_held)
  );

  always #5 clk = ~clk;

  // Model: a press is accepted once the synchronised level has been seen high on
  // D+1 consecutive edges, a release likewise for low; long press fires L edges
  // after the most recent start of an uninterrupted high stretch while pressed.
  int           cyc = 0;
  logic [N-1:0] kq1 = '0, kq2 = '0;
  int           run [N];
  bit           last_p [N];
  bit           m_pressed [N];
  bit           m_long [N];
  int           hold_start [N];
  bit           mp;
  logic [N-1:0] m_ks = '0, m_pp = '0, m_rp = '0, m_lp = '0, m_lh = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      kq1 = '0; kq2 = '0;
      m_ks = '0; m_pp = '0; m_rp = '0; m_lp = '0; m_lh = '0;
      for (int i = 0; i < N; i++) begin
        run[i] = 0; last_p[i] = 1'b0; m_pressed[i] = 1'b0; m_long[i] = 1'b0; hold_start[i] = 0;
      end
    end else begin
      cyc++;
      m_pp = '0; m_rp = '0; m_lp = '0;
      for (int i = 0; i < N; i++) begin
        mp = kq2[i];
        if (mp == last_p[i]) run[i]++;
        else begin run[i] = 1; last_p[i] = mp; end
        if (!m_pressed[i]) begin
          if (mp && run[i] == D + 1) begin
            m_pressed[i] = 1'b1; m_pp[i] = 1'b1; hold_start[i] = cyc;
          end
        end else if (!mp) begin
          if (run[i] == D + 1) begin
            m_pressed[i] = 1'b0; m_rp[i] = 1'b1; m_long[i] = 1'b0;
          end
        end else begin
          if (run[i] == 1) hold_start[i] = cyc;
          if (cyc - hold_start[i] == L && !m_long[i]) begin
            m_lp[i] = 1'b1; m_long[i] = 1'b1;
          end
        end
        m_ks[i] = m_pressed[i];
        m_lh[i] = m_long[i];
      end
      kq2 = kq1;
      kq1 = key;
    end
  end

  int checks = 0;
  int errors = 0;
  int press_cyc [N], rel_cyc [N], long_cyc [N];
  int n_press [N], n_rel [N], n_long [N];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int s, r, b;

  initial begin
    for (int i = 0; i < N; i++) begin
      press_cyc[i] = -1; rel_cyc[i] = -1; long_cyc[i] = -1;
      n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0;
    end
    fork
      forever begin
        @(negedge clk);
        cmp("key_state", 32'(key_state), 32'(m_ks));
        cmp("press_pulse", 32'(press_pulse), 32'(m_pp));
        cmp("release_pulse", 32'(release_pulse), 32'(m_rp));
        cmp("long_pulse", 32'(long_pulse), 32'(m_lp));
        cmp("long_held", 32'(long_held), 32'(m_lh));
        cmp("press_release_overlap", 32'(press_pulse & release_pulse), 32'd0);
        for (int i = 0; i < N; i++) begin
          if (press_pulse[i] === 1'b1)   begin press_cyc[i] = cyc; n_press[i]++; end
          if (release_pulse[i] === 1'b1) begin rel_cyc[i] = cyc;   n_rel[i]++;   end
          if (long_pulse[i] === 1'b1)    begin long_cyc[i] = cyc;  n_long[i]++;  end
        end
      end
      begin
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        cmp("rst_key_state", 32'(key_state), 32'd0);
        cmp("rst_press", 32'(press_pulse), 32'd0);
        cmp("rst_release", 32'(release_pulse), 32'd0);
        cmp("rst_long", 32'(long_pulse), 32'd0);
        cmp("rst_long_held", 32'(long_held), 32'd0);

        // Single press on key 0
        s = cyc + 1; key[0] = 1'b1; tick(20);
        cmp("t1_press_edge", 32'(press_cyc[0]), 32'(s + 10));
        cmp("t1_press_count", 32'(n_press[0]), 32'd1);
        cmp("t1_key_state", 32'(key_state), 32'b0001);
        cmp("t1_others", 32'(n_press[1] + n_press[2] + n_press[3]), 32'd0);
        r = cyc + 1; key[0] = 1'b0; tick(20);
        cmp("t1_release_edge", 32'(rel_cyc[0]), 32'(r + 10));
        cmp("t1_no_long", 32'(n_long[0]), 32'd0);

        // Short glitch on key 1
        key[1] = 1'b1; tick(5); key[1] = 1'b0; tick(20);
        cmp("t2_no_press", 32'(n_press[1]), 32'd0);
        cmp("t2_key_state", 32'(key_state[1]), 32'd0);

        // Long press on key 2
        s = cyc + 1; key[2] = 1'b1; tick(50);
        cmp("t3_press_edge", 32'(press_cyc[2]), 32'(s + 10));
        cmp("t3_long_edge", 32'(long_cyc[2]), 32'(s + 42));
        cmp("t3_long_held", 32'(long_held[2]), 32'd1);
        key[2] = 1'b0; tick(20);
        cmp("t3_release_edge", 32'(rel_cyc[2]), 32'(s + 60));
        cmp("t3_long_held_clr", 32'(long_held[2]), 32'd0);
        cmp("t3_key_state_clr", 32'(key_state[2]), 32'd0);
        cmp("t3_long_count", 32'(n_long[2]), 32'd1);

        // Release bounce on key 3 restarts long timing
        s = cyc + 1; key[3] = 1'b1; tick(20);
        cmp("t4_press_edge", 32'(press_cyc[3]), 32'(s + 10));
        b = cyc + 1; key[3] = 1'b0; tick(4); key[3] = 1'b1; tick(45);
        cmp("t4_no_release", 32'(n_rel[3]), 32'd0);
        cmp("t4_key_state", 32'(key_state[3]), 32'd1);
        cmp("t4_long_edge", 32'(long_cyc[3]), 32'(b + 38));
        key[3] = 1'b0; tick(3); key[3] = 1'b1; tick(45);
        cmp("t4_single_long", 32'(n_long[3]), 32'd1);
        cmp("t4_still_no_release", 32'(n_rel[3]), 32'd0);
        key[3] = 1'b0; tick(20);
        cmp("t4_release_count", 32'(n_rel[3]), 32'd1);
        cmp("t4_long_held_clr", 32'(long_held[3]), 32'd0);

        // Simultaneous presses on keys 0 and 3
        s = cyc + 1; key[0] = 1'b1; key[3] = 1'b1; tick(15);
        cmp("t5_press0_edge", 32'(press_cyc[0]), 32'(s + 10));
        cmp("t5_press3_edge", 32'(press_cyc[3]), 32'(s + 10));
        key = '0; tick(20);

        // Reset while key 1 is held
        s = cyc + 1; key[1] = 1'b1; tick(20);
        cmp("t6_press_edge", 32'(press_cyc[1]), 32'(s + 10));
        cmp("t6_held", 32'(key_state[1]), 32'd1);
        reset = 1'b1; #1;
        cmp("t6_rst_key_state", 32'(key_state), 32'd0);
        cmp("t6_rst_pulses", 32'(press_pulse | release_pulse | long_pulse), 32'd0);
        cmp("t6_rst_long_held", 32'(long_held), 32'd0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        r = cyc + 1; tick(15);
        cmp("t6_repress_edge", 32'(press_cyc[1]), 32'(r + 10));
        cmp("t6_press_count", 32'(n_press[1]), 32'd2);
        key[1] = 1'b0; tick(20);
        cmp("t6_release_count", 32'(n_rel[1]), 32'd1);
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
